pc_fetch: RTL

Program-counter and instruction-fetch unit for the single-issue processor. Holds the PC, issues sequential fetches to instruction memory, and hands one instruction per cycle to decode through a holding register. It consumes the taken/not-taken `sel` decision from the next-PC selector together with the branch immediate and absolute jump targets, then redirects the PC and squashes the wrong-path instruction.

---
 rtl/pc_fetch.sv | 106 ++++++++++
 1 files changed

// File: rtl/pc_fetch.sv
// Program counter and instruction-fetch unit: sequential fetch into a decode
// holding register, with branch/jump redirect, stall, halt and wait-state handling.
module pc_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        halt,
    input  logic        br_en,
    input  logic        br_sel,
    input  logic [31:0] br_pc4,
    input  logic [31:0] br_imm,
    input  logic        jmp_en,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic [31:0] inst_pc4,
    output logic        inst_valid,
    output logic        redirect
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        STALLED = 2'd1,
        HALTED  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [XLEN-1:0]   pc, pc_n;
    logic [XLEN-1:0]   inst_n, inst_pc4_n;
    logic              inst_valid_n, redirect_n;
    logic              take;
    logic [XLEN-1:0]   target;
    logic [XLEN-1:0]   pc_plus4;

    // Redirect decision: jump wins over a taken branch; branch offset is in words.
    assign take     = jmp_en | (br_en & br_sel);
    assign target   = jmp_en ? jmp_target
                             : XLEN'(br_pc4 + {br_imm[XLEN-3:0], 2'b00});
    assign pc_plus4 = XLEN'(pc + XLEN'(4));

    assign imem_addr = pc;
    assign imem_req  = (state == FETCH) && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FETCH;
            pc         <= RESET_PC;
            inst       <= '0;
            inst_pc4   <= '0;
            inst_valid <= 1'b0;
            redirect   <= 1'b0;
        end else begin
            state      <= state_n;
            pc         <= pc_n;
            inst       <= inst_n;
            inst_pc4   <= inst_pc4_n;
            inst_valid <= inst_valid_n;
            redirect   <= redirect_n;
        end
    end

    // Next-state and holding-register update, highest priority first.
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        inst_n       = inst;
        inst_pc4_n   = inst_pc4;
        inst_valid_n = inst_valid;
        redirect_n   = 1'b0;

        if (halt || state == HALTED) begin
            state_n      = HALTED;
            inst_valid_n = 1'b0;
        end else if (take) begin
            state_n      = FETCH;
            pc_n         = target;
            inst_valid_n = 1'b0;
            redirect_n   = 1'b1;
        end else if (state == FETCH) begin
            if (stall && inst_valid) begin
                state_n = STALLED;
            end else if (imem_ready) begin
                inst_n       = imem_rdata;
                inst_pc4_n   = pc_plus4;
                inst_valid_n = 1'b1;
                pc_n         = pc_plus4;
            end else if (!stall) begin
                inst_valid_n = 1'b0;
            end
        end else begin
            // STALLED: hold the instruction; restart fetch with a bubble on release
            if (!stall) begin
                inst_valid_n = 1'b0;
                state_n      = FETCH;
            end
        end
    end

endmodule
